// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//   Round-robin N-master to 1-slave arbiter for pipelined Wishbone
//   (cyc/stb/stall/ack). One master owns the slave at a time and keeps it
//   until it drops m_cyc and every accepted request has been acknowledged.
//   This guarantees that read data on the shared return path always belongs
//   to the current owner.
//
// Handshake: a request transfers on a cycle where stb is high and stall is
//   low ("accept"). Every accepted request is answered by exactly one ack,
//   in order, on a later cycle. cyc stays high from the first stb until the
//   last ack of the burst.
//
// Ports
//   sys_clk, sys_rst     clock (rising edge) and async active-low reset
//   m_cyc/m_stb/m_we     per-master Wishbone controls (one bit per master)
//   m_be/m_addr/m_data_out  per-master request fields, master i in slice i
//   m_stall/m_ack        per-master responses
//   m_data_in            slave read data broadcast to all masters
//   s_*                  single slave-side Wishbone port
//   grant                one-hot current owner, zero while idle
//   err_ack              sticky: slave acked with nothing outstanding
//   dbg_state            FSM state (0 idle, 1 own, 2 drain)
//   dbg_outst            accepted-but-unacknowledged request count
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [N_MASTERS-1:0]      m_cyc,
  input  logic [N_MASTERS-1:0]      m_stb,
  input  logic [N_MASTERS-1:0]      m_we,
  input  logic [N_MASTERS*DW/8-1:0] m_be,
  input  logic [N_MASTERS*AW-1:0]   m_addr,
  input  logic [N_MASTERS*DW-1:0]   m_data_out,
  output logic [N_MASTERS-1:0]      m_stall,
  output logic [N_MASTERS-1:0]      m_ack,
  output logic [DW-1:0]             m_data_in,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [DW/8-1:0]           s_be,
  output logic [AW-1:0]             s_addr,
  output logic [DW-1:0]             s_data_out,
  input  logic                      s_stall,
  input  logic                      s_ack,
  input  logic [DW-1:0]             s_data_in,
  output logic [N_MASTERS-1:0]      grant,
  output logic                      err_ack,
  output logic [1:0]                dbg_state,
  output logic [3:0]                dbg_outst
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int BW = DW / 8;

  logic [1:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]           outst_q, outst_d;
  logic                 err_ack_q;

  // Owner view, built as an AND-OR mux over the one-hot grant so that no
  // variable index is needed (and the mux reads all-zero while idle).
  logic          own_cyc, own_stb, own_we;
  logic [BW-1:0] own_be;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_dat;

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_be   = '0;
    own_addr = '0;
    own_dat  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        own_cyc  = m_cyc[i];
        own_stb  = m_stb[i];
        own_we   = m_we[i];
        own_be   = m_be[i*BW +: BW];
        own_addr = m_addr[i*AW +: AW];
        own_dat  = m_data_out[i*DW +: DW];
      end
    end
  end

  // Round-robin pick: scan offsets 0..N-1 from rr_ptr, first requester wins.
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] sel_grant;
  logic                 sel_found;

  assign req = m_cyc & m_stb;

  always_comb begin
    sel_grant = '0;
    sel_found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!sel_found && req[i] && (i == (int'(rr_ptr_q) + k) % N_MASTERS)) begin
          sel_found    = 1'b1;
          sel_grant[i] = 1'b1;
        end
      end
    end
  end

  // Pointer value after the current owner releases: the master after it.
  logic [IW-1:0] rr_next;

  always_comb begin
    rr_next = rr_ptr_q;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) rr_next = IW'((i + 1) % N_MASTERS);
    end
  end

  // An ack only counts when something is outstanding; otherwise it is a
  // stray from the slave (or from before a reset) and is swallowed.
  logic full, ack_ok, slave_stb, accept;

  assign full   = (outst_q == 4'(MAX_OUTST));
  assign ack_ok = s_ack && (outst_q != 4'd0);
  assign accept = slave_stb && !s_stall;

  always_comb begin
    s_cyc     = 1'b0;
    slave_stb = 1'b0;
    m_stall   = '1;
    m_ack     = '0;
    case (state_q)
      ST_OWN: begin
        s_cyc     = own_cyc;
        slave_stb = own_stb && !full;
        m_stall   = ~grant_q | {N_MASTERS{s_stall | full}};
        m_ack     = grant_q & {N_MASTERS{ack_ok}};
      end
      ST_DRAIN: begin
        s_cyc     = 1'b1;
        m_ack     = grant_q & {N_MASTERS{ack_ok}};
      end
      default: ;
    endcase
  end

  // Accept and ack in the same cycle cancel; neither can wrap because
  // accept needs ~full and ack_ok needs a non-zero count.
  always_comb begin
    outst_d = outst_q;
    case ({accept, ack_ok})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d = sel_grant;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        // Owner dropped cyc: leave now if nothing is pending after this
        // cycle, otherwise keep the bus until the slave finishes answering.
        if (!own_cyc) begin
          if (outst_d == 4'd0) begin
            grant_d  = '0;
            rr_ptr_d = rr_next;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (outst_d == 4'd0) begin
          grant_d  = '0;
          rr_ptr_d = rr_next;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      outst_q   <= 4'd0;
      err_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      outst_q  <= outst_d;
      if (s_ack && (outst_q == 4'd0)) err_ack_q <= 1'b1;
    end
  end

  assign s_stb      = slave_stb;
  assign s_we       = own_we;
  assign s_be       = own_be;
  assign s_addr     = own_addr;
  assign s_data_out = own_dat;
  assign m_data_in  = s_data_in;
  assign grant      = grant_q;
  assign err_ack    = err_ack_q;
  assign dbg_state  = state_q;
  assign dbg_outst  = outst_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_arbiter
//   Directed bench for wb_bus_arbiter with three masters and MAX_OUTST=4.
//   Inputs change 1 ns after each rising edge, outputs are sampled 2 ns after
//   it. Cycle labels Cn in the comments count cycles from the first grant.
// ---------------------------------------------------------------------------
module tb_wb_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*DW/8-1:0] m_be;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_data_out;
  logic [N-1:0]      m_stall, m_ack;
  logic [DW-1:0]     m_data_in;
  logic              s_cyc, s_stb, s_we;
  logic [DW/8-1:0]   s_be;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_data_out;
  logic              s_stall, s_ack;
  logic [DW-1:0]     s_data_in;
  logic [N-1:0]      grant;
  logic              err_ack;
  logic [1:0]        dbg_state;
  logic [3:0]        dbg_outst;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter #(
    .N_MASTERS(N), .AW(AW), .DW(DW), .MAX_OUTST(4)
  ) dut (
    .sys_clk(clk), .sys_rst(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_data_out(m_data_out),
    .m_stall(m_stall), .m_ack(m_ack), .m_data_in(m_data_in),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_be(s_be),
    .s_addr(s_addr), .s_data_out(s_data_out),
    .s_stall(s_stall), .s_ack(s_ack), .s_data_in(s_data_in),
    .grant(grant), .err_ack(err_ack),
    .dbg_state(dbg_state), .dbg_outst(dbg_outst)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    m_addr[i*AW +: AW] = a;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [N-1:0] rr_exp [4];

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    // ---------------- reset with masters 0 and 1 requesting --------------
    rst_n = 1'b0;
    m_cyc = 3'b011; m_stb = 3'b011; m_we = 3'b000;
    m_be = {4'hC, 4'h3, 4'hF};
    m_addr = '0; m_data_out = '0;
    m_data_out[DW +: DW] = 32'hD00D_0001;
    s_stall = 1'b0; s_ack = 1'b0; s_data_in = '0;
    set_addr(0, 32'h100);
    set_addr(1, 32'h1000);
    tick(); tick(); #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_stb", s_stb, 1'b0);
    chk("rst_m_stall", m_stall, 3'b111);
    chk("rst_m_ack", m_ack, 3'b000);
    chk("rst_err_ack", err_ack, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // ---------------- master 0: three back-to-back reads -----------------
    tick(); #1;                                            // C0
    chk("b2b_grant", grant, 3'b001);
    chk("b2b_state", dbg_state, ST_OWN);
    chk("b2b_s_stb0", s_stb, 1'b1);
    chk("b2b_addr0", s_addr, 32'h100);
    chk("b2b_stall", m_stall, 3'b110);
    tick(); set_addr(0, 32'h104); #1;                      // C1
    chk("b2b_ack_c1", m_ack, 3'b000);
    chk("b2b_outst_c1", dbg_outst, 4'd1);
    chk("b2b_addr1", s_addr, 32'h104);
    tick(); set_addr(0, 32'h108); s_ack = 1'b1; s_data_in = 32'hA; #1;   // C2
    chk("b2b_ack_a", m_ack, 3'b001);
    chk("b2b_data_a", m_data_in, 32'hA);
    chk("b2b_outst_c2", dbg_outst, 4'd2);
    tick(); m_stb[0] = 1'b0; s_data_in = 32'hB; #1;        // C3
    chk("b2b_ack_b", m_ack, 3'b001);
    chk("b2b_data_b", m_data_in, 32'hB);
    chk("b2b_outst_c3", dbg_outst, 4'd2);
    chk("b2b_s_stb_off", s_stb, 1'b0);
    chk("b2b_m1_stalled", m_stall, 3'b110);
    tick(); s_data_in = 32'hC; #1;                         // C4
    chk("b2b_ack_c", m_ack, 3'b001);
    chk("b2b_data_c", m_data_in, 32'hC);
    chk("b2b_outst_c4", dbg_outst, 4'd1);
    tick(); s_ack = 1'b0; m_cyc[0] = 1'b0; m_we = 3'b010; #1;   // C5
    chk("b2b_ack_none", m_ack, 3'b000);
    chk("b2b_outst_c5", dbg_outst, 4'd0);
    chk("b2b_grant_hold", grant, 3'b001);
    tick(); #1;                                            // C6
    chk("rel_grant_idle", grant, 3'b000);
    chk("rel_state_idle", dbg_state, ST_IDLE);
    chk("rel_s_cyc", s_cyc, 1'b0);
    chk("rel_stall", m_stall, 3'b111);

    // ---------------- master 1: writes against the outstanding limit ----
    tick(); #1;                                            // C7
    chk("lim_grant", grant, 3'b010);
    chk("lim_s_stb", s_stb, 1'b1);
    chk("lim_s_we", s_we, 1'b1);
    chk("lim_s_be", s_be, 4'h3);
    chk("lim_s_data", s_data_out, 32'hD00D_0001);
    chk("lim_addr0", s_addr, 32'h1000);
    chk("lim_stall0", m_stall, 3'b101);
    for (int k = 1; k <= 3; k++) begin                     // C8..C10
      tick(); set_addr(1, 32'h1000 + 32'(4 * k)); #1;
      chk("lim_s_stb_k", s_stb, 1'b1);
      chk("lim_outst_k", dbg_outst, 4'(k));
    end
    tick(); set_addr(1, 32'h1010); s_ack = 1'b1; #1;       // C11
    chk("lim_outst_full", dbg_outst, 4'd4);
    chk("lim_s_stb_full", s_stb, 1'b0);
    chk("lim_stall_full", m_stall, 3'b111);
    chk("lim_ack1", m_ack, 3'b010);
    tick(); s_ack = 1'b0; #1;                              // C12
    chk("lim_outst_after_ack", dbg_outst, 4'd3);
    chk("lim_fifth_stb", s_stb, 1'b1);
    chk("lim_fifth_addr", s_addr, 32'h1010);
    chk("lim_fifth_stall", m_stall, 3'b101);
    tick(); set_addr(1, 32'h1014); s_ack = 1'b1; #1;       // C13
    chk("lim_refull", dbg_outst, 4'd4);
    chk("lim_refull_stall", m_stall, 3'b111);
    tick(); #1;                                            // C14: accept + ack
    chk("lim_sixth_stb", s_stb, 1'b1);
    chk("lim_sixth_addr", s_addr, 32'h1014);
    chk("lim_outst_c14", dbg_outst, 4'd3);
    tick(); m_stb[1] = 1'b0; #1;                           // C15
    chk("sim_outst_same", dbg_outst, 4'd3);
    chk("sim_s_stb_off", s_stb, 1'b0);

    // ---------------- drain: master 1 drops cyc with 2 outstanding -------
    tick(); m_cyc[1] = 1'b0; s_ack = 1'b0; #1;             // C16
    chk("drn_outst2", dbg_outst, 4'd2);
    tick(); #1;                                            // C17
    chk("drn_state", dbg_state, ST_DRAIN);
    chk("drn_s_cyc", s_cyc, 1'b1);
    chk("drn_s_stb", s_stb, 1'b0);
    chk("drn_stall", m_stall, 3'b111);
    chk("drn_grant", grant, 3'b010);
    tick(); s_ack = 1'b1; #1;                              // C18
    chk("drn_ack1", m_ack, 3'b010);
    chk("drn_s_cyc_hold", s_cyc, 1'b1);
    tick(); #1;                                            // C19
    chk("drn_ack2", m_ack, 3'b010);
    chk("drn_outst1", dbg_outst, 4'd1);
    chk("drn_state2", dbg_state, ST_DRAIN);
    tick(); #1;                                            // C20: stray ack
    chk("spur_state", dbg_state, ST_IDLE);
    chk("spur_grant", grant, 3'b000);
    chk("spur_s_cyc", s_cyc, 1'b0);
    chk("spur_no_mack", m_ack, 3'b000);
    chk("spur_err_not_yet", err_ack, 1'b0);
    tick(); s_ack = 1'b0; #1;                              // C21
    chk("spur_err_set", err_ack, 1'b1);
    chk("spur_outst0", dbg_outst, 4'd0);

    // ---------------- master 2: reads with slave stall ------------------
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we = 3'b000; set_addr(2, 32'h200);
    tick(); #1;                                            // C22
    chk("stl_grant", grant, 3'b100);
    chk("stl_s_stb", s_stb, 1'b1);
    chk("stl_addr0", s_addr, 32'h200);
    tick(); set_addr(2, 32'h204); #1;                      // C23
    chk("stl_outst1", dbg_outst, 4'd1);
    tick(); set_addr(2, 32'h208); s_stall = 1'b1; s_ack = 1'b1; s_data_in = 32'hD1; #1;  // C24
    chk("stl_outst2", dbg_outst, 4'd2);
    chk("stl_stall", m_stall, 3'b111);
    chk("stl_ack_d1", m_ack, 3'b100);
    chk("stl_data_d1", m_data_in, 32'hD1);
    tick(); s_ack = 1'b0; #1;                              // C25
    chk("stl_outst_c25", dbg_outst, 4'd1);
    chk("stl_stall_c25", m_stall, 3'b111);
    tick(); s_ack = 1'b1; s_data_in = 32'hD2; #1;          // C26
    chk("stl_ack_d2", m_ack, 3'b100);
    chk("stl_data_d2", m_data_in, 32'hD2);
    chk("stl_outst_c26", dbg_outst, 4'd1);
    tick(); s_stall = 1'b0; s_ack = 1'b0; #1;              // C27
    chk("stl_outst_c27", dbg_outst, 4'd0);
    chk("stl_resume_stb", s_stb, 1'b1);
    chk("stl_resume_addr", s_addr, 32'h208);
    chk("stl_resume_stall", m_stall, 3'b011);
    tick(); set_addr(2, 32'h20C); s_ack = 1'b1; s_data_in = 32'hD3; #1;  // C28
    chk("stl_ack_d3", m_ack, 3'b100);
    chk("stl_data_d3", m_data_in, 32'hD3);
    chk("stl_outst_c28", dbg_outst, 4'd1);
    tick(); m_stb[2] = 1'b0; s_data_in = 32'hD4; #1;       // C29
    chk("stl_outst_same", dbg_outst, 4'd1);
    chk("stl_ack_d4", m_ack, 3'b100);
    chk("stl_data_d4", m_data_in, 32'hD4);
    tick(); s_ack = 1'b0; m_cyc[2] = 1'b0; #1;             // C30
    chk("stl_outst_c30", dbg_outst, 4'd0);
    chk("stl_state_c30", dbg_state, ST_OWN);
    tick(); m_cyc = 3'b111; m_stb = 3'b111; #1;            // C31
    chk("stl_released", grant, 3'b000);
    chk("stl_idle", dbg_state, ST_IDLE);
    chk("stl_err_sticky", err_ack, 1'b1);

    // ---------------- round robin over three continuous requesters ------
    for (int r = 0; r < 4; r++) begin
      tick(); #1;
      chk("rr_grant", grant, rr_exp[r]);
      chk("rr_s_stb", s_stb, 1'b1);
      tick();
      m_cyc = m_cyc & ~rr_exp[r];
      m_stb = m_stb & ~rr_exp[r];
      s_ack = 1'b1; s_data_in = 32'h50 + 32'(r);
      #1;
      chk("rr_ack", m_ack, rr_exp[r]);
      chk("rr_data", m_data_in, 32'h50 + 32'(r));
      tick();
      m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b0;
      #1;
      chk("rr_gap", grant, 3'b000);
    end
    m_cyc = 3'b000; m_stb = 3'b000;
    tick(); tick(); #1;
    chk("end_grant", grant, 3'b000);
    chk("end_state", dbg_state, ST_IDLE);

    // ---------------- asynchronous reset clears the sticky flag ---------
    rst_n = 1'b0;
    #1;
    chk("arst_err_clear", err_ack, 1'b0);
    chk("arst_grant", grant, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
